// File: rtl/board_region_writer.sv
`default_nettype none
// ============================================================================
// Module      : board_region_writer
// Description : Rectangle fill engine for the background frame RAM write port.
//               Latches a rectangle request and writes one palette index per
//               clock, row by row, suppressing writes that fall off the board.
// Revision    : 1.0 - initial release
// ============================================================================
module board_region_writer #(
    parameter int IMG_W  = 280,
    parameter int IMG_H  = 310,
    parameter int ADDR_W = 19,
    parameter int PIX_W  = 5
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [8:0]        req_x,
    input  logic [8:0]        req_y,
    input  logic [4:0]        req_w,
    input  logic [4:0]        req_h,
    input  logic [PIX_W-1:0]  req_color,
    input  logic              hold,
    output logic [ADDR_W-1:0] write_address,
    output logic [PIX_W-1:0]  data_In,
    output logic              we,
    output logic              busy,
    output logic              done
);

    localparam logic [ADDR_W-1:0] c_IMG_W_A  = ADDR_W'(IMG_W);
    localparam logic [9:0]        c_IMG_W_10 = 10'(IMG_W);
    localparam logic [9:0]        c_IMG_H_10 = 10'(IMG_H);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SETUP = 2'd1,
        S_FILL  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t              r_state;
    logic [8:0]          r_x;
    logic [8:0]          r_y;
    logic [4:0]          r_w;
    logic [4:0]          r_h;
    logic [PIX_W-1:0]    r_color;
    logic [4:0]          r_col;
    logic [4:0]          r_row;
    logic [ADDR_W-1:0]   r_row_base;
    logic [ADDR_W-1:0]   r_write_address;
    logic [PIX_W-1:0]    r_data_in;
    logic                r_we;
    logic                r_busy;
    logic                r_done;
    logic                r_req_ready;

    // Clip test: 10-bit sums so a column/row offset can never wrap back on-board
    logic [9:0] w_x_sum;
    logic [9:0] w_y_sum;
    logic       w_pix_on_board;
    logic       w_last_col;
    logic       w_last_row;

    assign w_x_sum        = {1'b0, r_x} + {5'b0, r_col};
    assign w_y_sum        = {1'b0, r_y} + {5'b0, r_row};
    assign w_pix_on_board = (w_x_sum < c_IMG_W_10) && (w_y_sum < c_IMG_H_10);
    assign w_last_col     = (r_col == (r_w - 5'd1));
    assign w_last_row     = (r_row == (r_h - 5'd1));

    // Request handshake, rectangle walk and registered RAM write port
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state         <= S_IDLE;
            r_x             <= '0;
            r_y             <= '0;
            r_w             <= '0;
            r_h             <= '0;
            r_color         <= '0;
            r_col           <= '0;
            r_row           <= '0;
            r_row_base      <= '0;
            r_write_address <= '0;
            r_data_in       <= '0;
            r_we            <= 1'b0;
            r_busy          <= 1'b0;
            r_done          <= 1'b0;
            r_req_ready     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_we   <= 1'b0;
                    r_done <= 1'b0;
                    // Only accept once ready has actually been advertised
                    if (r_req_ready && req_valid) begin
                        r_x         <= req_x;
                        r_y         <= req_y;
                        r_w         <= req_w;
                        r_h         <= req_h;
                        r_color     <= req_color;
                        r_req_ready <= 1'b0;
                        r_busy      <= 1'b1;
                        r_state     <= S_SETUP;
                    end else begin
                        r_req_ready <= 1'b1;
                        r_busy      <= 1'b0;
                    end
                end
                S_SETUP: begin
                    r_we       <= 1'b0;
                    r_row_base <= (ADDR_W'(r_y) * c_IMG_W_A) + ADDR_W'(r_x);
                    r_col      <= '0;
                    r_row      <= '0;
                    if ((r_w == 5'd0) || (r_h == 5'd0)) begin
                        r_state <= S_DONE;
                    end else begin
                        r_state <= S_FILL;
                    end
                end
                S_FILL: begin
                    if (hold) begin
                        r_we <= 1'b0;
                    end else begin
                        r_we            <= w_pix_on_board;
                        r_write_address <= r_row_base + ADDR_W'(r_col);
                        r_data_in       <= r_color;
                        if (w_last_col) begin
                            r_col <= '0;
                            if (w_last_row) begin
                                r_state <= S_DONE;
                            end else begin
                                r_row      <= r_row + 5'd1;
                                r_row_base <= r_row_base + c_IMG_W_A;
                            end
                        end else begin
                            r_col <= r_col + 5'd1;
                        end
                    end
                end
                S_DONE: begin
                    r_we    <= 1'b0;
                    r_done  <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign req_ready     = r_req_ready;
    assign write_address = r_write_address;
    assign data_In       = r_data_in;
    assign we            = r_we;
    assign busy          = r_busy;
    assign done          = r_done;

endmodule
`default_nettype wire

// File: tb/tb_board_region_writer.sv
`default_nettype none
// ============================================================================
// Module      : tb_board_region_writer
// Description : Directed self-checking bench for board_region_writer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_board_region_writer;

    localparam int c_ADDR_W = 19;
    localparam int c_PIX_W  = 5;

    logic                Clk;
    logic                Reset_n;
    logic                req_valid;
    logic                req_ready;
    logic [8:0]          req_x;
    logic [8:0]          req_y;
    logic [4:0]          req_w;
    logic [4:0]          req_h;
    logic [c_PIX_W-1:0]  req_color;
    logic                hold;
    logic [c_ADDR_W-1:0] write_address;
    logic [c_PIX_W-1:0]  data_In;
    logic                we;
    logic                busy;
    logic                done;

    int total;
    int bad;

    board_region_writer #(
        .IMG_W  (280),
        .IMG_H  (310),
        .ADDR_W (c_ADDR_W),
        .PIX_W  (c_PIX_W)
    ) u_dut (
        .Clk           (Clk),
        .Reset_n       (Reset_n),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_x         (req_x),
        .req_y         (req_y),
        .req_w         (req_w),
        .req_h         (req_h),
        .req_color     (req_color),
        .hold          (hold),
        .write_address (write_address),
        .data_In       (data_In),
        .we            (we),
        .busy          (busy),
        .done          (done)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Advance one rising edge and sample just after it
    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Wait (bounded) for req_ready, then present a request for exactly one edge
    task automatic start_req(input logic [8:0] x, input logic [8:0] y,
                             input logic [4:0] w, input logic [4:0] h,
                             input logic [4:0] c);
        int n;
        n = 0;
        while (req_ready !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        if (req_ready !== 1'b1) begin
            total++; bad++;
            $display("FAIL start_req: req_ready=%b required 1 within 20 cycles", req_ready);
        end
        req_x = x; req_y = y; req_w = w; req_h = h; req_color = c;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        req_x = 9'd0; req_y = 9'd0; req_w = 5'd0; req_h = 5'd0; req_color = 5'd0;
    endtask

    task automatic test_reset();
        Reset_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if ({we, busy, done, req_ready} !== 4'b0000) begin
                bad++;
                $display("FAIL reset_outs: we/busy/done/ready=%b required 0000", {we, busy, done, req_ready});
            end
        end
        total++;
        if (write_address !== 19'd0 || data_In !== 5'd0) begin
            bad++;
            $display("FAIL reset_data: addr=%0d data=%0d required 0 0", write_address, data_In);
        end
        Reset_n = 1'b1;
        tick();
        total++;
        if (req_ready !== 1'b1 || busy !== 1'b0 || we !== 1'b0) begin
            bad++;
            $display("FAIL reset_release: ready=%b busy=%b we=%b required 1 0 0", req_ready, busy, we);
        end
    endtask

    task automatic test_basic();
        logic [18:0] exp_addr [4];
        exp_addr[0] = 19'd5610; exp_addr[1] = 19'd5611;
        exp_addr[2] = 19'd5890; exp_addr[3] = 19'd5891;
        start_req(9'd10, 9'd20, 5'd2, 5'd2, 5'd3);
        tick(); // T+1
        total++;
        if (we !== 1'b0 || busy !== 1'b1 || req_ready !== 1'b0) begin
            bad++;
            $display("FAIL basic_setup: we=%b busy=%b ready=%b required 0 1 0", we, busy, req_ready);
        end
        for (int k = 0; k < 4; k++) begin
            tick(); // T+2+k
            total++;
            if (we !== 1'b1 || write_address !== exp_addr[k] || data_In !== 5'd3) begin
                bad++;
                $display("FAIL basic_write%0d: we=%b addr=%0d data=%0d required 1 %0d 3",
                         k, we, write_address, data_In, exp_addr[k]);
            end
        end
        tick(); // T+6
        total++;
        if (done !== 1'b1 || we !== 1'b0) begin
            bad++;
            $display("FAIL basic_done: done=%b we=%b required 1 0", done, we);
        end
        tick(); // T+7
        total++;
        if (busy !== 1'b0 || done !== 1'b0 || req_ready !== 1'b1) begin
            bad++;
            $display("FAIL basic_idle: busy=%b done=%b ready=%b required 0 0 1", busy, done, req_ready);
        end
    endtask

    task automatic test_clip();
        start_req(9'd279, 9'd0, 5'd2, 5'd1, 5'd7);
        tick(); // T+1
        tick(); // T+2
        total++;
        if (we !== 1'b1 || write_address !== 19'd279 || data_In !== 5'd7) begin
            bad++;
            $display("FAIL clip_write: we=%b addr=%0d data=%0d required 1 279 7", we, write_address, data_In);
        end
        tick(); // T+3
        total++;
        if (we !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("FAIL clip_suppress: we=%b done=%b required 0 0", we, done);
        end
        tick(); // T+4
        total++;
        if (done !== 1'b1) begin
            bad++;
            $display("FAIL clip_done: done=%b required 1", done);
        end
    endtask

    task automatic test_zero_size();
        int writes;
        writes = 0;
        start_req(9'd5, 9'd5, 5'd0, 5'd5, 5'd1);
        tick(); // T+1
        if (we === 1'b1) writes++;
        total++;
        if (done !== 1'b0) begin
            bad++;
            $display("FAIL zero_early: done=%b required 0", done);
        end
        tick(); // T+2
        if (we === 1'b1) writes++;
        total++;
        if (done !== 1'b1) begin
            bad++;
            $display("FAIL zero_done: done=%b required 1", done);
        end
        total++;
        if (writes != 0) begin
            bad++;
            $display("FAIL zero_writes: writes=%0d required 0", writes);
        end
    endtask

    task automatic test_hold_busy_ignore();
        int writes;
        int done_cycle;
        int addr_errs;
        int hold_errs;
        int ready_errs;
        logic [18:0] exp;
        writes = 0; done_cycle = -1; addr_errs = 0; hold_errs = 0; ready_errs = 0;
        start_req(9'd100, 9'd100, 5'd16, 5'd16, 5'd9);
        for (int c = 1; c <= 400 && done_cycle < 0; c++) begin
            tick(); // now after edge T+c
            if (we === 1'b1) begin
                exp = 19'd28100 + 19'(writes / 16) * 19'd280 + 19'(writes % 16);
                if (write_address !== exp || data_In !== 5'd9) addr_errs++;
                writes++;
            end
            if (c >= 51 && c <= 53 && we !== 1'b0) hold_errs++;
            if (done === 1'b1) done_cycle = c;
            else if (req_ready !== 1'b0) ready_errs++;
            // drive for the next edge
            hold = (c >= 50 && c <= 52);
            if (c >= 20 && c <= 24) begin
                req_valid = 1'b1; req_x = 9'd3; req_y = 9'd3; req_w = 5'd1; req_h = 5'd1; req_color = 5'd1;
            end else begin
                req_valid = 1'b0;
            end
        end
        hold = 1'b0;
        req_valid = 1'b0;
        total++;
        if (writes != 256) begin
            bad++;
            $display("FAIL hold_count: writes=%0d required 256", writes);
        end
        total++;
        if (addr_errs != 0) begin
            bad++;
            $display("FAIL hold_addr: address/data errors=%0d required 0", addr_errs);
        end
        total++;
        if (hold_errs != 0) begin
            bad++;
            $display("FAIL hold_we: writes during hold=%0d required 0", hold_errs);
        end
        total++;
        if (done_cycle != 261) begin
            bad++;
            $display("FAIL hold_done: done at T+%0d required T+261", done_cycle);
        end
        total++;
        if (ready_errs != 0) begin
            bad++;
            $display("FAIL hold_ready: ready-high cycles while busy=%0d required 0", ready_errs);
        end
        tick();
        total++;
        if (req_ready !== 1'b1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL ignore_idle: ready=%b busy=%b required 1 0", req_ready, busy);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            total++;
            if (busy !== 1'b0 || we !== 1'b0) begin
                bad++;
                $display("FAIL ignore_second: busy=%b we=%b required 0 0", busy, we);
            end
        end
    endtask

    task automatic test_reset_mid();
        int writes;
        int late;
        writes = 0; late = 0;
        start_req(9'd0, 9'd0, 5'd16, 5'd16, 5'd4);
        for (int c = 0; c < 40 && writes < 5; c++) begin
            tick();
            if (we === 1'b1) writes++;
        end
        total++;
        if (writes != 5) begin
            bad++;
            $display("FAIL rstmid_start: writes=%0d required 5", writes);
        end
        Reset_n = 1'b0;
        #1;
        total++;
        if (we !== 1'b0 || busy !== 1'b0 || req_ready !== 1'b0 || write_address !== 19'd0) begin
            bad++;
            $display("FAIL rstmid_async: we=%b busy=%b ready=%b addr=%0d required 0 0 0 0",
                     we, busy, req_ready, write_address);
        end
        tick();
        tick();
        Reset_n = 1'b1;
        for (int c = 0; c < 30; c++) begin
            tick();
            if (we !== 1'b0 || busy !== 1'b0) late++;
        end
        total++;
        if (late != 0) begin
            bad++;
            $display("FAIL rstmid_resume: active cycles after reset=%0d required 0", late);
        end
        start_req(9'd1, 9'd1, 5'd1, 5'd1, 5'd2);
        tick(); // T+1
        tick(); // T+2
        total++;
        if (we !== 1'b1 || write_address !== 19'd281 || data_In !== 5'd2) begin
            bad++;
            $display("FAIL rstmid_new: we=%b addr=%0d data=%0d required 1 281 2", we, write_address, data_In);
        end
        tick(); // T+3
        total++;
        if (done !== 1'b1 || we !== 1'b0) begin
            bad++;
            $display("FAIL rstmid_done: done=%b we=%b required 1 0", done, we);
        end
    endtask

    initial begin
        total = 0; bad = 0;
        Reset_n = 1'b0; req_valid = 1'b0; hold = 1'b0;
        req_x = 9'd0; req_y = 9'd0; req_w = 5'd0; req_h = 5'd0; req_color = 5'd0;
        #1;
        test_reset();
        test_basic();
        test_clip();
        test_zero_size();
        test_hold_busy_ignore();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
